// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// Size codes, cause codes, FSM states and the registered bundles.
package mem_access_unit_pkg;

    localparam int NBITS   = 32;
    localparam int TNBITS  = 2;
    localparam int TIMEOUT = 15;
    localparam int CW      = $clog2(TIMEOUT + 1);

    localparam logic [TNBITS-1:0] SZ_WORD = 2'b00;
    localparam logic [TNBITS-1:0] SZ_BYTE = 2'b01;
    localparam logic [TNBITS-1:0] SZ_HALF = 2'b10;
    localparam logic [TNBITS-1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        C_OK  = 2'b00,
        C_MIS = 2'b01,
        C_TMO = 2'b10,
        C_ILL = 2'b11
    } cause_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [NBITS-1:0]  addr;
        logic [NBITS-1:0]  wdata;
        logic [3:0]        be;
        logic [1:0]        off;
        logic [TNBITS-1:0] size;
        logic              cero;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [NBITS-1:0]  data;
        logic [TNBITS-1:0] size;
        logic              cero;
        cause_t            cause;
    } wb_t;

    function automatic logic aligned(
        input logic [TNBITS-1:0] sz,
        input logic [1:0]        a
    );
        logic ok;
        unique case (sz)
            SZ_HALF: ok = !a[0];
            SZ_WORD: ok = (a == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage (master) and memory (slave).
// Request fields are held stable while mem_req is high.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic             mem_req;
    logic             mem_we;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ready;
    logic [NBITS-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_access_unit_byte_lane_align.sv
// Combinational lane steering: store replication / byte enables
// and right-alignment of the loaded word.
module mem_access_unit_byte_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]        off,
    input  logic [TNBITS-1:0] size,
    input  logic [NBITS-1:0]  store_data,
    input  logic [NBITS-1:0]  rdata,
    output logic [3:0]        be,
    output logic [NBITS-1:0]  wdata,
    output logic [NBITS-1:0]  load_data
);

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        unique case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Upper bits are left as-is; the WB filter does the extension.
    assign load_data = rdata >> {off, 3'b000};

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: one handshaked data-memory access per load/store,
// pipeline stall until memory answers, registered result to WB.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [NBITS-1:0]   i_addr,
    input  logic [NBITS-1:0]   i_store_data,
    input  logic [TNBITS-1:0]  i_size,
    input  logic               i_cero,
    input  logic               i_flush,
    output logic               o_stall,
    mem_access_unit_if.master  bus,
    output logic               o_valid,
    output logic [NBITS-1:0]   o_data,
    output logic [TNBITS-1:0]  o_size,
    output logic               o_cero,
    output logic [1:0]         o_cause
);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flush_q, flush_d;
    req_t            rq_q, rq_d;
    wb_t             wb_q, wb_d;

    logic              is_mem, rw_ok, size_ok, legal;
    logic              done, drop;
    logic [1:0]        a_off;
    logic [TNBITS-1:0] a_size;
    logic [3:0]        a_be;
    logic [NBITS-1:0]  a_wdata, a_load;

    assign is_mem  = i_mem_read | i_mem_write;
    assign rw_ok   = i_mem_read ^ i_mem_write;
    assign size_ok = (i_size != SZ_ILL);
    assign legal   = i_valid & rw_ok & size_ok
                   & aligned(i_size, i_addr[1:0]);

    // Store side uses the incoming op, load side the latched one.
    assign a_off  = (state_q == REQ) ? rq_q.off  : i_addr[1:0];
    assign a_size = (state_q == REQ) ? rq_q.size : i_size;

    mem_access_unit_byte_lane_align u_align (
        .off        (a_off),
        .size       (a_size),
        .store_data (i_store_data),
        .rdata      (bus.mem_rdata),
        .be         (a_be),
        .wdata      (a_wdata),
        .load_data  (a_load)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        rq_d     = rq_q;
        wb_d     = wb_q;
        wb_d.valid = 1'b0;
        o_stall  = 1'b0;
        done     = 1'b0;
        drop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_valid && !i_flush) begin
                    if (legal) begin
                        state_d    = REQ;
                        o_stall    = 1'b1;
                        cnt_d      = '0;
                        flush_d    = 1'b0;
                        rq_d.req   = 1'b1;
                        rq_d.we    = i_mem_write;
                        rq_d.addr  = {i_addr[NBITS-1:2], 2'b00};
                        rq_d.wdata = i_mem_write ? a_wdata : '0;
                        rq_d.be    = i_mem_write ? a_be : 4'b1111;
                        rq_d.off   = i_addr[1:0];
                        rq_d.size  = i_size;
                        rq_d.cero  = i_cero;
                    end else begin
                        wb_d.valid = 1'b1;
                        wb_d.data  = is_mem ? '0 : i_addr;
                        wb_d.size  = i_size;
                        wb_d.cero  = i_cero;
                        if (!is_mem)
                            wb_d.cause = C_OK;
                        else if (!rw_ok || !size_ok)
                            wb_d.cause = C_ILL;
                        else
                            wb_d.cause = C_MIS;
                    end
                end
            end
            REQ: begin
                o_stall = !bus.mem_ready;
                flush_d = flush_q | i_flush;
                drop    = flush_q | i_flush;
                if (bus.mem_ready) begin
                    done = 1'b1;
                    if (!drop) begin
                        wb_d.data  = rq_q.we ? '0 : a_load;
                        wb_d.cause = C_OK;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done = 1'b1;
                    if (!drop) begin
                        wb_d.data  = '0;
                        wb_d.cause = C_TMO;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    flush_d = 1'b0;
                    rq_d    = '0;
                    if (!drop) begin
                        wb_d.valid = 1'b1;
                        wb_d.size  = rq_q.size;
                        wb_d.cero  = rq_q.cero;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            rq_q    <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            rq_q    <= rq_d;
            wb_q    <= wb_d;
        end
    end

    assign bus.mem_req   = rq_q.req;
    assign bus.mem_we    = rq_q.we;
    assign bus.mem_addr  = rq_q.addr;
    assign bus.mem_wdata = rq_q.wdata;
    assign bus.mem_be    = rq_q.be;

    assign o_valid = wb_q.valid;
    assign o_data  = wb_q.data;
    assign o_size  = wb_q.size;
    assign o_cero  = wb_q.cero;
    assign o_cause = wb_q.cause;

endmodule
